// File: rtl/interpolator.sv
// Integer-factor interpolator: one input sample per INTERP_FACTOR outputs, zero-order hold or zero-stuffed.
// Optional sticky underrun detection is built when INTERP_UNDERRUN_DETECT_EN is defined.
module interpolator #(
    parameter int DATA_WIDTH    = 32,
    parameter int INTERP_FACTOR = 4,
    parameter int HOLD_MODE     = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  underrun
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_PHASE = CNT_WIDTH'(INTERP_FACTOR - 1);

    state_t                  state;
    logic [CNT_WIDTH-1:0]    phase;
    logic [DATA_WIDTH-1:0]   hold;
    logic                    at_last;
    logic                    xfer;
    logic [CNT_WIDTH-1:0]    next_phase;

    // phase is the phase of the sample currently on data_out
    assign at_last       = (phase == LAST_PHASE);
    assign data_in_ready = en && ((state == IDLE) || at_last);
    assign xfer          = data_in_valid && data_in_ready;
    assign next_phase    = phase + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            hold       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (!en) begin
            data_valid <= 1'b0;
        end else if (xfer) begin
            // a new sample goes straight out as phase 0, keeping reloads gapless
            hold       <= data_in;
            data_out   <= data_in;
            data_valid <= 1'b1;
            phase      <= '0;
            state      <= RUN;
        end else if (state == RUN) begin
            if (at_last) begin
                phase      <= '0;
                state      <= IDLE;
                data_valid <= 1'b0;
            end else begin
                phase      <= next_phase;
                data_valid <= 1'b1;
                data_out   <= (HOLD_MODE == 0) ? '0 : hold;
            end
        end else begin
            data_valid <= 1'b0;
        end
    end

`ifdef INTERP_UNDERRUN_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (en && (state == RUN) && at_last && !xfer) begin
            underrun <= 1'b1;
        end
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_interpolator.sv
// Bench for interpolator: three instances (F=4 hold, F=4 zero-stuff, F=1) checked every cycle against
// a per-sample output-count model, plus literal output sequences for the directed scenarios.
module tb_interpolator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] din = '0;
    logic        dvld = 1'b0;

    logic [31:0] a_out [3];
    logic        a_vld [3];
    logic        a_rdy [3];
    logic        a_und [3];

    logic [31:0] dout_h, dout_z, dout_p;
    logic        vld_h, vld_z, vld_p, rdy_h, rdy_z, rdy_p, und_h, und_z, und_p;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    interpolator #(.DATA_WIDTH(32), .INTERP_FACTOR(4), .HOLD_MODE(1), .CNT_WIDTH(16)) u_h (
        .clk(clk), .rst(rst), .en(en), .data_in(din), .data_in_valid(dvld),
        .data_in_ready(rdy_h), .data_out(dout_h), .data_valid(vld_h), .underrun(und_h));
    interpolator #(.DATA_WIDTH(32), .INTERP_FACTOR(4), .HOLD_MODE(0), .CNT_WIDTH(16)) u_z (
        .clk(clk), .rst(rst), .en(en), .data_in(din), .data_in_valid(dvld),
        .data_in_ready(rdy_z), .data_out(dout_z), .data_valid(vld_z), .underrun(und_z));
    interpolator #(.DATA_WIDTH(32), .INTERP_FACTOR(1), .HOLD_MODE(1), .CNT_WIDTH(16)) u_p (
        .clk(clk), .rst(rst), .en(en), .data_in(din), .data_in_valid(dvld),
        .data_in_ready(rdy_p), .data_out(dout_p), .data_valid(vld_p), .underrun(und_p));

    assign a_out[0] = dout_h;  assign a_vld[0] = vld_h;  assign a_rdy[0] = rdy_h;  assign a_und[0] = und_h;
    assign a_out[1] = dout_z;  assign a_vld[1] = vld_z;  assign a_rdy[1] = rdy_z;  assign a_und[1] = und_z;
    assign a_out[2] = dout_p;  assign a_vld[2] = vld_p;  assign a_rdy[2] = rdy_p;  assign a_und[2] = und_p;

`ifdef INTERP_UNDERRUN_DETECT_EN
    localparam logic UND_EXP = 1'b1;
`else
    localparam logic UND_EXP = 1'b0;
`endif

    // Model: a sample in progress and how many of its F outputs have been emitted so far.
    typedef struct {
        logic        active;
        int          k;
        logic [31:0] cur;
        logic [31:0] out;
        logic        vld;
        logic        und;
    } mstate_t;

    mstate_t m [3];
    int      f_of [3] = '{4, 4, 1};
    bit      h_of [3] = '{1'b1, 1'b0, 1'b1};

    function automatic logic exp_ready(mstate_t s, int f, logic e);
        return e && (!s.active || s.k == f);
    endfunction

    function automatic mstate_t model_reset();
        mstate_t s;
        s.active = 1'b0; s.k = 0; s.cur = '0; s.out = '0; s.vld = 1'b0; s.und = 1'b0;
        return s;
    endfunction

    function automatic mstate_t model_step(mstate_t s, int f, bit h, logic e, logic v, logic [31:0] d);
        mstate_t n = s;
        if (!e) begin
            n.vld = 1'b0;
        end else if (exp_ready(s, f, e) && v) begin
            n.active = 1'b1; n.k = 1; n.cur = d; n.out = d; n.vld = 1'b1;
        end else if (s.active && s.k < f) begin
            n.k = s.k + 1;
            n.out = h ? s.cur : 32'h0;
            n.vld = 1'b1;
        end else if (s.active) begin
            n.active = 1'b0; n.vld = 1'b0; n.und = UND_EXP;
        end else begin
            n.vld = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) m[i] = model_reset();
            else     m[i] = model_step(m[i], f_of[i], h_of[i], en, dvld, din);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("inst%0d_valid", i), {31'b0, a_vld[i]}, {31'b0, m[i].vld});
                if (m[i].vld) chk($sformatf("inst%0d_data", i), a_out[i], m[i].out);
                chk($sformatf("inst%0d_ready", i), {31'b0, a_rdy[i]}, {31'b0, exp_ready(m[i], f_of[i], en)});
                chk($sformatf("inst%0d_underrun", i), {31'b0, a_und[i]}, {31'b0, m[i].und});
            end
        end
    end

    logic [31:0] q_h [$];
    logic [31:0] q_z [$];
    logic [31:0] q_p [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (vld_h) q_h.push_back(dout_h);
            if (vld_z) q_z.push_back(dout_z);
            if (vld_p) q_p.push_back(dout_p);
        end
    end

    task automatic chk_q(input string name, input logic [31:0] q [$], input logic [31:0] e [$]);
        chk({name, "_len"}, 32'(q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < q.size(); i++)
            chk($sformatf("%s_%0d", name, i), q[i], e[i]);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        q_h.delete(); q_z.delete(); q_p.delete();
    endtask

    // holds the sample until the F=4 instances accept it
    task automatic send(input logic [31:0] v);
        bit ok = 1'b0;
        din = v;
        dvld = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (rdy_h) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        dvld = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted value=%h", v);
        end
    endtask

    initial begin
        logic [31:0] e [$];

        // reset state
        tick(2);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_out%0d", i), a_out[i], 32'h0);
            chk($sformatf("reset_vld%0d", i), {31'b0, a_vld[i]}, 32'h0);
            chk($sformatf("reset_und%0d", i), {31'b0, a_und[i]}, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        en = 1'b1;
        tick(2);

        // back-to-back, continuous valid
        clear_q();
        send(32'h11);
        send(32'h22);
        tick(6);
        e = '{32'h11, 32'h11, 32'h11, 32'h11, 32'h22, 32'h22, 32'h22, 32'h22};
        chk_q("hold_seq", q_h, e);
        e = '{32'h11, 32'h0, 32'h0, 32'h0, 32'h22, 32'h0, 32'h0, 32'h0};
        chk_q("zs_seq1", q_z, e);
        chk("und_after_gap", {31'b0, und_h}, {31'b0, UND_EXP});

        clear_q();
        send(32'hA5);
        send(32'h5A);
        tick(6);
        e = '{32'hA5, 32'h0, 32'h0, 32'h0, 32'h5A, 32'h0, 32'h0, 32'h0};
        chk_q("zs_seq2", q_z, e);

        // single sample then idle
        clear_q();
        send(32'h33);
        tick(6);
        e = '{32'h33, 32'h33, 32'h33, 32'h33};
        chk_q("single", q_h, e);
        chk("single_idle_vld", {31'b0, vld_h}, 32'h0);

        // stall with en low after phase 1 is on the output
        clear_q();
        send(32'h44);
        tick(1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("stall_hold_out", dout_h, 32'h44);
            chk("stall_vld", {31'b0, vld_h}, 32'h0);
            chk("stall_rdy", {31'b0, rdy_h}, 32'h0);
        end
        en = 1'b1;
        tick(6);
        e = '{32'h44, 32'h44, 32'h44, 32'h44};
        chk_q("stall_hold", q_h, e);
        e = '{32'h44, 32'h0, 32'h0, 32'h0};
        chk_q("stall_zs", q_z, e);

        // F=1 pass-through, one cycle latency
        clear_q();
        for (int v = 1; v <= 3; v++) begin
            din = 32'(v);
            dvld = 1'b1;
            chk("pass_rdy", {31'b0, rdy_p}, 32'h1);
            tick(1);
            chk("pass_out", dout_p, 32'(v));
            chk("pass_vld", {31'b0, vld_p}, 32'h1);
        end
        dvld = 1'b0;
        tick(6);
        e = '{32'h1, 32'h2, 32'h3};
        chk_q("pass_seq", q_p, e);

        // asynchronous reset mid-sample
        send(32'h77);
        tick(1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out", dout_h, 32'h0);
        chk("arst_vld", {31'b0, vld_h}, 32'h0);
        chk("arst_und", {31'b0, und_h}, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);
        clear_q();
        send(32'h88);
        tick(6);
        e = '{32'h88, 32'h88, 32'h88, 32'h88};
        chk_q("after_rst", q_h, e);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            en   = ($urandom_range(99) < 85);
            dvld = ($urandom_range(99) < 70);
            din  = $urandom();
            rst  = ($urandom_range(399) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
